bp_be_issue_queue_nw: RTL and testbench
=======================================

// Module: bp_be_issue_queue_nw
// PURPOSE
//  Parametrised N-wide speculative instruction queue between FE queue and BE issue.
//  Accepts up to width_p entries/cycle, presents up to width_p oldest unread entries,
//  retires up to width_p entries/cycle via a commit (checkpoint) pointer.
//  Supports roll-back of speculative reads on mispredict/exception, and clear of unread entries on redirect.
// PARAMETERS
//  width_p      2    lanes per cycle for enqueue, read and commit (1..8)
//  els_p        16   entries; power of 2, >= 2*width_p
//  data_width_p 64   payload bits per entry
//  (local) ptr_w = clog2(els_p)+1 (MSB = wrap bit); cnt_w = clog2(width_p+1)
// PORTS
//  clk_i         in   1                   clock
//  reset_i       in   1                   sync active-high reset
//  clr_v_i       in   1                   drop all unread entries (wptr := next rptr)
//  roll_v_i      in   1                   rewind rptr to next cptr (replay uncommitted)
//  commit_cnt_i  in   cnt_w               entries retired this cycle (advances cptr)
//  enq_v_i       in   width_p             per-lane enqueue valid, thermometer from lane 0
//  enq_data_i    in   width_p*data_width_p lane i payload at [i*data_width_p+:data_width_p]
//  enq_ready_o   out  1                   all width_p lanes may enqueue
//  deq_data_o    out  width_p*data_width_p lane i = entry at rptr+i
//  deq_v_o       out  width_p             thermometer, lane i valid iff i < avail
//  deq_yumi_cnt_i in  cnt_w               entries consumed this cycle (<= popcount(deq_v_o))
// BEHAVIOUR
//  - Pointers wptr_r, rptr_r, cptr_r, ptr_w bits, modulo 2*els_p; index = low bits.
//  - Reset: all ptrs 0; enq_ready_o=1, deq_v_o=0; storage contents not reset.
//  - avail = wptr_r - rptr_r; occ = wptr_r - cptr_r; free = els_p - occ (ptr_w arithmetic).
//  - enq_ready_o = ~clr_v_i & (free >= width_p). Lane writes only when ready; n_enq = popcount(enq_v_i&ready).
//  - Lane i writes mem[wptr_r+i]; wrap across els_p boundary legal in one cycle.
//  - Storage write-sync, read-async; written data visible on deq_data_o next cycle (no bypass).
//  - deq_v_o lane i = ~roll_v_i & (i < avail); deq_data_o lanes with deq_v_o=0 are don't-care.
//  - Next-state (one cycle, all concurrent):
//    cptr_n = cptr_r + commit_cnt_i
//    rptr_n = roll_v_i ? cptr_n : rptr_r + deq_yumi_cnt_i
//    wptr_n = clr_v_i ? rptr_n : wptr_r + n_enq
//  - roll_v_i: yumi ignored; replayed entries reappear on deq_v_o next cycle starting at cptr_n.
//  - clr_v_i & roll_v_i together: wptr_n = rptr_n = cptr_n -> queue empty, occ=0.
//  - clr_v_i: enq blocked that cycle; same-cycle yumi honoured before clear.
//  - Commit and enqueue same cycle at full: free uses registered cptr_r (no same-cycle credit).
//  - Invariants (asserted, X-safe): cptr<=rptr<=wptr in modular order; commit_cnt_i<=rptr_r-cptr_r;
//    deq_yumi_cnt_i<=popcount(deq_v_o); enq_v_i thermometer; counts <= width_p.
//  - reset_i mid-operation: next cycle all ptrs 0, in-flight entries lost, no writes on reset cycle.
// TESTING
//  1 reset; enq 2,2,2 (width 2, els 16) -> deq_v_o=11 from cycle 1, avail=6, enq_ready_o=1.
//  2 fill to occ=14 -> enq_ready_o=1; occ=15 (single enq) -> enq_ready_o=0 until commit_cnt_i>=1.
//  3 wrap: wptr=15, enq 2 lanes -> writes idx 15 and 0, wrap bit flips; data read back in order.
//  4 enq A..F, yumi 4, commit 1, roll -> next cycle deq_data_o lanes = B,C; avail=5.
//  5 avail=4, yumi 1 with clr_v_i -> next cycle avail=0, deq_v_o=00, then enq resumes at old rptr+1.
//  6 roll+clr+commit 2 same cycle, then reset mid-stream -> all ptrs 0, deq_v_o=0, enq_ready_o=1.

Source files
------------

// File: rtl/bp_be_issue_queue_nw_if.sv
// Handshake bundle between the FE-side producer / BE-side consumer and the
// N-wide speculative issue queue.
interface bp_be_issue_queue_nw_if #(
    parameter int width_p      = 2,
    parameter int data_width_p = 64
);
    localparam int cnt_w = $clog2(width_p + 1);

    logic                            clr_v_i;
    logic                            roll_v_i;
    logic [cnt_w-1:0]                commit_cnt_i;
    logic [width_p-1:0]              enq_v_i;
    logic [width_p*data_width_p-1:0] enq_data_i;
    logic                            enq_ready_o;
    logic [width_p*data_width_p-1:0] deq_data_o;
    logic [width_p-1:0]              deq_v_o;
    logic [cnt_w-1:0]                deq_yumi_cnt_i;

    modport master (
        output clr_v_i, roll_v_i, commit_cnt_i, enq_v_i, enq_data_i, deq_yumi_cnt_i,
        input  enq_ready_o, deq_data_o, deq_v_o
    );

    modport slave (
        input  clr_v_i, roll_v_i, commit_cnt_i, enq_v_i, enq_data_i, deq_yumi_cnt_i,
        output enq_ready_o, deq_data_o, deq_v_o
    );
endinterface

// File: rtl/bp_be_issue_queue_nw.sv
// N-wide speculative issue queue: write/read/commit pointers over a circular
// buffer, with roll-back of uncommitted reads and clear of unread entries.
module bp_be_issue_queue_nw #(
    parameter int width_p      = 2,
    parameter int els_p        = 16,
    parameter int data_width_p = 64
) (
    input logic                    clk_i,
    input logic                    reset_i,
    bp_be_issue_queue_nw_if.slave  io
);
    localparam int idx_w = $clog2(els_p);
    localparam int ptr_w = idx_w + 1;
    localparam int cnt_w = $clog2(width_p + 1);

    logic [data_width_p-1:0] mem [els_p];

    logic [ptr_w-1:0] wptr_reg, rptr_reg, cptr_reg;
    logic [ptr_w-1:0] wptr_next, rptr_next, cptr_next;
    logic [ptr_w-1:0] avail, occ, rc_dist;
    logic [ptr_w:0]   free;
    logic             enq_ready;
    logic [width_p-1:0] wr_en;
    logic [idx_w-1:0]   wr_idx [width_p];
    logic [cnt_w-1:0]   n_enq;
    logic [cnt_w-1:0]   deq_cnt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign avail   = wptr_reg - rptr_reg;
    assign occ     = wptr_reg - cptr_reg;
    assign rc_dist = rptr_reg - cptr_reg;
    assign free    = (ptr_w+1)'(els_p) - {1'b0, occ};

    // Free space counts from the registered commit pointer only.
    assign enq_ready      = ~io.clr_v_i & (free >= (ptr_w+1)'(width_p));
    assign io.enq_ready_o = enq_ready;

    generate
        for (genvar gi = 0; gi < width_p; gi++) begin : g_lane
            assign wr_en[gi]  = io.enq_v_i[gi] & enq_ready & ~reset_i;
            assign wr_idx[gi] = wptr_reg[idx_w-1:0] + idx_w'(gi);
            assign io.deq_v_o[gi] = ~io.roll_v_i & (avail > ptr_w'(gi));
            assign io.deq_data_o[gi*data_width_p +: data_width_p] =
                mem[rptr_reg[idx_w-1:0] + idx_w'(gi)];
        end
    endgenerate

    always_comb begin
        n_enq   = '0;
        deq_cnt = '0;
        for (int i = 0; i < width_p; i++) begin
            n_enq   = n_enq + cnt_w'(io.enq_v_i[i] & enq_ready);
            deq_cnt = deq_cnt + cnt_w'(io.deq_v_o[i]);
        end
    end

    // A roll takes precedence over consumption; a clear collapses onto the new read pointer.
    always_comb begin
        cptr_next = cptr_reg + ptr_w'(io.commit_cnt_i);
        rptr_next = rptr_reg + ptr_w'(io.deq_yumi_cnt_i);
        wptr_next = wptr_reg + ptr_w'(n_enq);
        if (io.roll_v_i) begin
            rptr_next = cptr_next;
        end
        if (io.clr_v_i) begin
            wptr_next = rptr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            cptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
            cptr_reg <= cptr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < width_p; i++) begin
            if (wr_en[i]) begin
                mem[wr_idx[i]] <= io.enq_data_i[i*data_width_p +: data_width_p];
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!$isunknown({io.enq_v_i, io.commit_cnt_i, io.deq_yumi_cnt_i,
                                 io.clr_v_i, io.roll_v_i}));
            assert (rc_dist <= occ);
            assert (occ <= ptr_w'(els_p));
            assert (ptr_w'(io.commit_cnt_i) <= rc_dist);
            assert (io.deq_yumi_cnt_i <= deq_cnt);
            assert ((io.enq_v_i & (io.enq_v_i + width_p'(1))) == '0);
            assert (io.commit_cnt_i <= cnt_w'(width_p));
            assert (io.deq_yumi_cnt_i <= cnt_w'(width_p));
        end
    end
`endif
endmodule

// File: tb/tb_bp_be_issue_queue_nw.sv
// Directed bench for the 2-wide, 16-entry issue queue: fill, wrap, roll-back,
// clear and mid-stream reset, with hand-computed expectations.
module tb_bp_be_issue_queue_nw;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bp_be_issue_queue_nw_if #(.width_p(2), .data_width_p(64)) q_if ();

    bp_be_issue_queue_nw #(.width_p(2), .els_p(16), .data_width_p(64)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .io      (q_if)
    );

    function automatic logic [63:0] lane(input int i);
        return q_if.deq_data_o[i*64 +: 64];
    endfunction

    task automatic drive(input logic [1:0] ev, input logic [63:0] d1, input logic [63:0] d0,
                         input logic [1:0] yumi, input logic [1:0] commit,
                         input logic clr, input logic roll);
        q_if.enq_v_i        = ev;
        q_if.enq_data_i     = {d1, d0};
        q_if.deq_yumi_cnt_i = yumi;
        q_if.commit_cnt_i   = commit;
        q_if.clr_v_i        = clr;
        q_if.roll_v_i       = roll;
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 64'h0, 64'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        $display("txn t=%0t rst=%b enq_v=%b yumi=%0d commit=%0d clr=%b roll=%b rdy=%b deq_v=%b",
                 $time, reset_i, q_if.enq_v_i, q_if.deq_yumi_cnt_i, q_if.commit_cnt_i,
                 q_if.clr_v_i, q_if.roll_v_i, q_if.enq_ready_o, q_if.deq_v_o);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle();
        cyc();
        cyc();
        reset_i = 1'b0;
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (q_if.enq_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got %b want 1", q_if.enq_ready_o);
        end
        n_checks++;
        if (q_if.deq_v_o !== 2'b00) begin
            n_fail++; $display("FAIL reset_deq_v got %b want 00", q_if.deq_v_o);
        end
    endtask

    task automatic test_enq_basic();
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 64'(2*k+2), 64'(2*k+1), 2'd0, 2'd0, 1'b0, 1'b0);
            n_checks++;
            if (q_if.enq_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL basic_ready[%0d] got %b want 1", k, q_if.enq_ready_o);
            end
            cyc();
            idle();
            n_checks++;
            if (q_if.deq_v_o !== 2'b11 || lane(0) !== 64'd1 || lane(1) !== 64'd2) begin
                n_fail++;
                $display("FAIL basic_deq[%0d] got v=%b %0h,%0h want v=11 1,2",
                         k, q_if.deq_v_o, lane(0), lane(1));
            end
        end
        n_checks++;
        if (q_if.enq_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL basic_ready_avail6 got %b want 1", q_if.enq_ready_o);
        end
    endtask

    task automatic test_full();
        for (int k = 3; k < 7; k++) begin
            drive(2'b11, 64'(2*k+2), 64'(2*k+1), 2'd0, 2'd0, 1'b0, 1'b0);
            cyc();
        end
        idle();
        n_checks++;
        if (q_if.enq_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL full_occ14_ready got %b want 1", q_if.enq_ready_o);
        end
        drive(2'b01, 64'h0, 64'd15, 2'd0, 2'd0, 1'b0, 1'b0);
        cyc();
        idle();
        n_checks++;
        if (q_if.enq_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL full_occ15_ready got %b want 0", q_if.enq_ready_o);
        end
        drive(2'b11, 64'hBAD, 64'hBAD, 2'd2, 2'd0, 1'b0, 1'b0);
        n_checks++;
        if (lane(0) !== 64'd1 || lane(1) !== 64'd2) begin
            n_fail++; $display("FAIL full_head got %0h,%0h want 1,2", lane(0), lane(1));
        end
        cyc();
        drive(2'b11, 64'hBAD, 64'hBAD, 2'd0, 2'd1, 1'b0, 1'b0);
        n_checks++;
        if (q_if.enq_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL full_commit_same_cycle_ready got %b want 0", q_if.enq_ready_o);
        end
        cyc();
        idle();
        n_checks++;
        if (q_if.enq_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL full_after_commit_ready got %b want 1", q_if.enq_ready_o);
        end
    endtask

    task automatic test_wrap();
        int r;
        int av;
        logic [1:0] yumi;
        drive(2'b11, 64'd17, 64'd16, 2'd0, 2'd0, 1'b0, 1'b0);
        cyc();
        idle();
        n_checks++;
        if (q_if.enq_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL wrap_full_ready got %b want 0", q_if.enq_ready_o);
        end
        r = 2;
        while (r < 17) begin
            av   = 17 - r;
            yumi = (av >= 2) ? 2'd2 : 2'd1;
            drive(2'b00, 64'h0, 64'h0, yumi, 2'd0, 1'b0, 1'b0);
            n_checks++;
            if (q_if.deq_v_o !== ((av >= 2) ? 2'b11 : 2'b01) || lane(0) !== 64'(r+1)
                || (av >= 2 && lane(1) !== 64'(r+2))) begin
                n_fail++;
                $display("FAIL wrap_read[r=%0d] got v=%b %0h,%0h want avail=%0d %0h,%0h",
                         r, q_if.deq_v_o, lane(0), lane(1), av, r+1, r+2);
            end
            cyc();
            r += int'(yumi);
        end
        idle();
        n_checks++;
        if (q_if.deq_v_o !== 2'b00) begin
            n_fail++; $display("FAIL wrap_drained got %b want 00", q_if.deq_v_o);
        end
    endtask

    task automatic test_rollback();
        do_reset();
        drive(2'b11, 64'hB, 64'hA, 2'd0, 2'd0, 1'b0, 1'b0); cyc();
        drive(2'b11, 64'hD, 64'hC, 2'd0, 2'd0, 1'b0, 1'b0); cyc();
        drive(2'b11, 64'hF, 64'hE, 2'd0, 2'd0, 1'b0, 1'b0); cyc();
        drive(2'b00, 64'h0, 64'h0, 2'd2, 2'd0, 1'b0, 1'b0); cyc();
        n_checks++;
        if (lane(0) !== 64'hC || lane(1) !== 64'hD) begin
            n_fail++; $display("FAIL roll_pre got %0h,%0h want c,d", lane(0), lane(1));
        end
        drive(2'b00, 64'h0, 64'h0, 2'd2, 2'd0, 1'b0, 1'b0); cyc();
        drive(2'b00, 64'h0, 64'h0, 2'd0, 2'd1, 1'b0, 1'b1);
        n_checks++;
        if (q_if.deq_v_o !== 2'b00) begin
            n_fail++; $display("FAIL roll_cycle_deq_v got %b want 00", q_if.deq_v_o);
        end
        cyc();
        idle();
        n_checks++;
        if (q_if.deq_v_o !== 2'b11 || lane(0) !== 64'hB || lane(1) !== 64'hC) begin
            n_fail++;
            $display("FAIL roll_replay got v=%b %0h,%0h want 11 b,c", q_if.deq_v_o, lane(0), lane(1));
        end
        drive(2'b00, 64'h0, 64'h0, 2'd2, 2'd0, 1'b0, 1'b0); cyc();
        idle();
        n_checks++;
        if (q_if.deq_v_o !== 2'b11 || lane(0) !== 64'hD || lane(1) !== 64'hE) begin
            n_fail++;
            $display("FAIL roll_replay2 got v=%b %0h,%0h want 11 d,e", q_if.deq_v_o, lane(0), lane(1));
        end
        drive(2'b00, 64'h0, 64'h0, 2'd2, 2'd0, 1'b0, 1'b0); cyc();
        idle();
        n_checks++;
        if (q_if.deq_v_o !== 2'b01 || lane(0) !== 64'hF) begin
            n_fail++; $display("FAIL roll_last got v=%b %0h want 01 f", q_if.deq_v_o, lane(0));
        end
        drive(2'b00, 64'h0, 64'h0, 2'd1, 2'd0, 1'b0, 1'b0); cyc();
        idle();
        n_checks++;
        if (q_if.deq_v_o !== 2'b00) begin
            n_fail++; $display("FAIL roll_avail5_empty got %b want 00", q_if.deq_v_o);
        end
    endtask

    task automatic test_clear();
        do_reset();
        drive(2'b11, 64'h22, 64'h21, 2'd0, 2'd0, 1'b0, 1'b0); cyc();
        drive(2'b11, 64'h24, 64'h23, 2'd0, 2'd0, 1'b0, 1'b0); cyc();
        drive(2'b11, 64'hDEAD, 64'hDEAD, 2'd1, 2'd0, 1'b1, 1'b0);
        n_checks++;
        if (q_if.enq_ready_o !== 1'b0 || lane(0) !== 64'h21) begin
            n_fail++;
            $display("FAIL clr_cycle got rdy=%b %0h want rdy=0 21", q_if.enq_ready_o, lane(0));
        end
        cyc();
        idle();
        n_checks++;
        if (q_if.deq_v_o !== 2'b00 || q_if.enq_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_after got v=%b rdy=%b want 00 1", q_if.deq_v_o, q_if.enq_ready_o);
        end
        // Occupancy restarts at 1 (the consumed-but-uncommitted entry): seven pairs reach 15.
        for (int k = 0; k < 7; k++) begin
            drive(2'b11, 64'(8'h32 + 2*k), 64'(8'h31 + 2*k), 2'd0, 2'd0, 1'b0, 1'b0);
            n_checks++;
            if (q_if.enq_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL clr_refill_ready[%0d] got %b want 1", k, q_if.enq_ready_o);
            end
            cyc();
            if (k == 0) begin
                idle();
                n_checks++;
                if (q_if.deq_v_o !== 2'b11 || lane(0) !== 64'h31 || lane(1) !== 64'h32) begin
                    n_fail++;
                    $display("FAIL clr_resume got v=%b %0h,%0h want 11 31,32",
                             q_if.deq_v_o, lane(0), lane(1));
                end
            end
        end
        idle();
        n_checks++;
        if (q_if.enq_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL clr_occ15_ready got %b want 0", q_if.enq_ready_o);
        end
    endtask

    task automatic test_roll_clr_reset();
        drive(2'b00, 64'h0, 64'h0, 2'd2, 2'd0, 1'b0, 1'b0); cyc();
        drive(2'b00, 64'h0, 64'h0, 2'd0, 2'd2, 1'b1, 1'b1);
        n_checks++;
        if (q_if.deq_v_o !== 2'b00 || q_if.enq_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rc_cycle got v=%b rdy=%b want 00 0", q_if.deq_v_o, q_if.enq_ready_o);
        end
        cyc();
        idle();
        n_checks++;
        if (q_if.deq_v_o !== 2'b00 || q_if.enq_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rc_empty got v=%b rdy=%b want 00 1", q_if.deq_v_o, q_if.enq_ready_o);
        end
        drive(2'b11, 64'h52, 64'h51, 2'd0, 2'd0, 1'b0, 1'b0); cyc();
        idle();
        n_checks++;
        if (q_if.deq_v_o !== 2'b11 || lane(0) !== 64'h51 || lane(1) !== 64'h52) begin
            n_fail++;
            $display("FAIL rc_enq got v=%b %0h,%0h want 11 51,52", q_if.deq_v_o, lane(0), lane(1));
        end
        reset_i = 1'b1;
        drive(2'b11, 64'h54, 64'h53, 2'd0, 2'd0, 1'b0, 1'b0);
        cyc();
        reset_i = 1'b0;
        idle();
        n_checks++;
        if (q_if.deq_v_o !== 2'b00 || q_if.enq_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset got v=%b rdy=%b want 00 1", q_if.deq_v_o, q_if.enq_ready_o);
        end
        drive(2'b11, 64'h62, 64'h61, 2'd0, 2'd0, 1'b0, 1'b0); cyc();
        idle();
        n_checks++;
        if (q_if.deq_v_o !== 2'b11 || lane(0) !== 64'h61 || lane(1) !== 64'h62) begin
            n_fail++;
            $display("FAIL post_reset_enq got v=%b %0h,%0h want 11 61,62",
                     q_if.deq_v_o, lane(0), lane(1));
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_enq_basic();
        test_full();
        test_wrap();
        test_rollback();
        test_clear();
        test_roll_clr_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
